lidar_frame_tx: RTL and testbench

Serializes one LiDAR scan packet (header, CT, LSN, FSA, LSA, checksum, distance samples) onto a UART line in the same 8N1 byte format and field order that the distance-processing receive path decodes. The block buffers samples, computes the XOR checksum, then streams the frame, so the receive chain can be driven without the physical sensor. It sits at the sensor end of the link and is used as a sensor emulator on the board and as a stimulus source in benches.

---
 rtl/lidar_frame_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 72 +++++++
 rtl/lidar_frame_tx.sv | 183 ++++++++++++++++++
 tb/tb_lidar_frame_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lidar_frame_pkg.sv
// Shared constants and types for the LiDAR scan-packet transmitter.
package lidar_frame_pkg;

  localparam logic [7:0]  HDR_B0  = 8'hAA;
  localparam logic [7:0]  HDR_B1  = 8'h55;
  localparam logic [15:0] PH_WORD = 16'h55AA;
  localparam int          HDR_LEN = 10;
  // Wide enough for a 10 + 2*255 byte frame.
  localparam int          IDX_W   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
    word_byte = hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte shifter. A new byte is accepted on the final cycle of the
// current stop bit, so consecutive bytes leave with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       line
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  logic [9:0]    shift_r;
  logic [CW-1:0] clk_cnt_r;
  logic [3:0]    bit_cnt_r;
  logic          busy_r;
  logic          line_r;
  logic          ready_s;

  // Load window: idle, or last cycle of the stop bit.
  always_comb begin
    ready_s = 1'b0;
    if (!busy_r) begin
      ready_s = 1'b1;
    end else if ((bit_cnt_r == 4'd9) && (clk_cnt_r == LAST_CLK)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Bit-time counter and LSB-first shifter; line is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r   <= 10'h3FF;
      clk_cnt_r <= {CW{1'b0}};
      bit_cnt_r <= 4'd0;
      busy_r    <= 1'b0;
      line_r    <= 1'b1;
    end else if (load && ready_s) begin
      shift_r   <= {1'b1, data, 1'b0};
      clk_cnt_r <= {CW{1'b0}};
      bit_cnt_r <= 4'd0;
      busy_r    <= 1'b1;
      line_r    <= 1'b0;
    end else if (busy_r) begin
      if (clk_cnt_r == LAST_CLK) begin
        clk_cnt_r <= {CW{1'b0}};
        if (bit_cnt_r == 4'd9) begin
          busy_r <= 1'b0;
          line_r <= 1'b1;
        end else begin
          bit_cnt_r <= bit_cnt_r + 4'd1;
          shift_r   <= {1'b1, shift_r[9:1]};
          line_r    <= shift_r[1];
        end
      end else begin
        clk_cnt_r <= clk_cnt_r + CW'(1);
      end
    end
  end

  assign ready = ready_s;
  assign busy  = busy_r;
  assign line  = line_r;

endmodule

// File: rtl/lidar_frame_tx.sv
// LiDAR scan-packet serializer: buffers samples, folds the header fields into the
// XOR checksum at start, then streams the frame as 8N1 bytes. Macro: LIDAR_TX_CKSUM_EN.
module lidar_frame_tx
  import lidar_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_SAMPLES  = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        samp_valid,
  input  logic [15:0] samp_data,
  output logic        samp_ready,
  input  logic        start,
  input  logic [7:0]  ct,
  input  logic [15:0] fsa,
  input  logic [15:0] lsa,
  output logic        transmitData,
  output logic        busy,
  output logic        done
);

  localparam int AW = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;

  state_t           state_r, state_nx_s;
  logic [7:0]       count_r;
  logic [15:0]      buf_r [MAX_SAMPLES];
  logic [7:0]       ct_r, lsn_r;
  logic [15:0]      fsa_r, lsa_r, cs_r;
  logic [IDX_W-1:0] byte_idx_r;
  logic             done_r, ready_en_r;

  logic [IDX_W-1:0] frame_len_s;
  logic [8:0]       rd_idx_s;
  logic [15:0]      rd_word_s, cs_fold_s;
  logic [7:0]       tx_byte_s;
  logic             load_s, push_s, start_go_s, clear_s, samp_ready_s;
  logic             uart_ready_s, uart_busy_s, uart_line_s;

  assign frame_len_s = IDX_W'(HDR_LEN) + {1'b0, lsn_r, 1'b0};
  assign rd_idx_s    = 9'((byte_idx_r - IDX_W'(HDR_LEN)) >> 1);
  assign rd_word_s   = (rd_idx_s < 9'(MAX_SAMPLES)) ? buf_r[rd_idx_s[AW-1:0]] : 16'h0000;

`ifdef LIDAR_TX_CKSUM_EN
  logic [15:0] acc_r;

  // Sample half of the checksum, accumulated as pushes are accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= 16'h0000;
    end else if (clear_s) begin
      acc_r <= 16'h0000;
    end else if (push_s) begin
      acc_r <= acc_r ^ samp_data;
    end
  end

  assign cs_fold_s = PH_WORD ^ {count_r, ct} ^ fsa ^ lsa ^ acc_r;
`else
  assign cs_fold_s = 16'h0000;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: SEND ends once every byte is loaded and the last stop bit completes.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = start ? SEND : IDLE;
      SEND:    state_nx_s = (uart_ready_s && (byte_idx_r == frame_len_s)) ? DONE : SEND;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM outputs: handshake, byte load strobe and field mux.
  always_comb begin
    start_go_s   = 1'b0;
    clear_s      = 1'b0;
    load_s       = 1'b0;
    samp_ready_s = 1'b0;
    tx_byte_s    = 8'h00;
    if (ready_en_r && (state_r == IDLE) && (count_r < 8'(MAX_SAMPLES)) && !start) begin
      samp_ready_s = 1'b1;
    end else begin
      samp_ready_s = 1'b0;
    end
    case (state_r)
      IDLE:    start_go_s = start;
      SEND:    load_s     = uart_ready_s && (byte_idx_r != frame_len_s);
      DONE:    clear_s    = 1'b1;
      default: clear_s    = 1'b0;
    endcase
    case (byte_idx_r)
      10'd0:   tx_byte_s = HDR_B0;
      10'd1:   tx_byte_s = HDR_B1;
      10'd2:   tx_byte_s = ct_r;
      10'd3:   tx_byte_s = lsn_r;
      10'd4:   tx_byte_s = fsa_r[7:0];
      10'd5:   tx_byte_s = fsa_r[15:8];
      10'd6:   tx_byte_s = lsa_r[7:0];
      10'd7:   tx_byte_s = lsa_r[15:8];
      10'd8:   tx_byte_s = cs_r[7:0];
      10'd9:   tx_byte_s = cs_r[15:8];
      default: tx_byte_s = word_byte(rd_word_s, byte_idx_r[0]);
    endcase
  end

  assign push_s = samp_valid && samp_ready_s;

  // Sample count; cleared when a frame completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 8'd0;
    end else if (clear_s) begin
      count_r <= 8'd0;
    end else if (push_s) begin
      count_r <= count_r + 8'd1;
    end
  end

  // Sample storage; validity is tracked by count_r alone.
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_r[count_r[AW-1:0]] <= samp_data;
    end
  end

  // Header fields captured at start, and the next-byte pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ct_r       <= 8'h00;
      lsn_r      <= 8'h00;
      fsa_r      <= 16'h0000;
      lsa_r      <= 16'h0000;
      cs_r       <= 16'h0000;
      byte_idx_r <= 10'd0;
    end else if (start_go_s) begin
      ct_r       <= ct;
      lsn_r      <= count_r;
      fsa_r      <= fsa;
      lsa_r      <= lsa;
      cs_r       <= cs_fold_s;
      byte_idx_r <= 10'd0;
    end else if (load_s) begin
      byte_idx_r <= byte_idx_r + 10'd1;
    end
  end

  // Registered done pulse; samp_ready held low until the cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r     <= 1'b0;
      ready_en_r <= 1'b0;
    end else begin
      done_r     <= (state_nx_s == DONE);
      ready_en_r <= 1'b1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .data  (tx_byte_s),
    .ready (uart_ready_s),
    .busy  (uart_busy_s),
    .line  (uart_line_s)
  );

  assign samp_ready   = samp_ready_s;
  assign transmitData = uart_line_s;
  assign busy         = uart_busy_s;
  assign done         = done_r;

endmodule

// File: tb/tb_lidar_frame_tx.sv
// Bench for lidar_frame_tx: table of frames plus hand sequences for full buffer,
// ignored start/push, mid-frame reset and push-with-start.
`timescale 1ns/1ps
module tb_lidar_frame_tx;

  localparam int CPB  = 4;
  localparam int MAXS = 40;

`ifdef LIDAR_TX_CKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        samp_valid;
  logic [15:0] samp_data;
  logic        samp_ready;
  logic        start;
  logic [7:0]  ct;
  logic [15:0] fsa, lsa;
  logic        transmitData, busy, done;

  always #5 clk = ~clk;

  lidar_frame_tx #(.CLKS_PER_BIT(CPB), .MAX_SAMPLES(MAXS)) dut (
    .clk          (clk),
    .reset        (reset),
    .samp_valid   (samp_valid),
    .samp_data    (samp_data),
    .samp_ready   (samp_ready),
    .start        (start),
    .ct           (ct),
    .fsa          (fsa),
    .lsa          (lsa),
    .transmitData (transmitData),
    .busy         (busy),
    .done         (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver model: samples each bit at its centre on the falling clock edge.
  logic [7:0]  rx_q[$];
  int          rx_err = 0;
  initial begin
    bit         act;
    int         cyc;
    int         b;
    logic [7:0] sh;
    act = 1'b0; cyc = 0; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (transmitData === 1'b0) begin
          act = 1'b1;
          cyc = 0;
        end
      end else begin
        cyc++;
        if ((cyc % CPB) == (CPB / 2)) begin
          b = cyc / CPB;
          if (b == 0) begin
            if (transmitData !== 1'b0) rx_err++;
          end else if (b <= 8) begin
            sh[b-1] = transmitData;
          end else begin
            if (transmitData !== 1'b1) rx_err++;
            rx_q.push_back(sh);
            act = 1'b0;
          end
        end
      end
    end
  end

  logic [15:0] pushed_q[$];

  task automatic push(input logic [15:0] d, output logic acc);
    @(negedge clk);
    samp_valid = 1'b1;
    samp_data  = d;
    #1;
    acc = samp_ready;
    @(posedge clk);
    #1;
    samp_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [15:0] f, input logic [15:0] l,
                           input bit disturb, input bit push_at_start, output int busy_cyc);
    int guard;
    rx_q.delete();
    rx_err = 0;
    @(negedge clk);
    start = 1'b1; ct = c; fsa = f; lsa = l;
    if (push_at_start) begin
      samp_valid = 1'b1;
      samp_data  = 16'h7777;
    end
    #1;
    if (push_at_start) check("ready_with_start", samp_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; samp_valid = 1'b0;
    ct = 8'h5A; fsa = 16'hDEAD; lsa = 16'hBEEF;
    @(negedge clk);
    check("busy_at_start", busy, 1'b1);
    check("line_start_bit", transmitData, 1'b0);
    busy_cyc = 0;
    guard    = 0;
    while ((busy === 1'b1) && (guard < 20000)) begin
      busy_cyc++;
      if (disturb && (busy_cyc == 100)) begin
        start = 1'b1; ct = 8'hEE; samp_valid = 1'b1; samp_data = 16'h4321;
        #1;
        check("ready_in_send", samp_ready, 1'b0);
      end else if (disturb && (busy_cyc == 101)) begin
        start = 1'b0; samp_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) check("busy_timeout", 32'd1, 32'd0);
    check("done_pulse", done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("no_restart", busy, 1'b0);
  endtask

  task automatic compare_frame(input logic [7:0] c, input logic [15:0] f, input logic [15:0] l,
                               input logic [15:0] cs_full);
    logic [7:0]  e[$];
    logic [15:0] cs;
    cs = CS_EN ? cs_full : 16'h0000;
    e = {8'hAA, 8'h55, c, 8'(pushed_q.size()), f[7:0], f[15:8], l[7:0], l[15:8], cs[7:0], cs[15:8]};
    foreach (pushed_q[i]) begin
      e.push_back(pushed_q[i][7:0]);
      e.push_back(pushed_q[i][15:8]);
    end
    check("frame_bytes", rx_q.size(), e.size());
    check("rx_framing", rx_err, 0);
    if (rx_q.size() == e.size()) begin
      foreach (e[i]) check($sformatf("byte%0d", i), rx_q[i], e[i]);
    end
  endtask

  typedef struct packed {
    logic [7:0]       n;
    logic [3:0][15:0] s;
    logic [7:0]       c;
    logic [15:0]      f;
    logic [15:0]      l;
    logic [15:0]      cs;
    logic [15:0]      cyc;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic        acc;
    int          bc;
    logic [15:0] cs_m;

    vt[0] = '{n: 8'd1, s: {16'h0000, 16'h0000, 16'h0000, 16'h0ABC}, c: 8'h00,
              f: 16'h1234, l: 16'h1234, cs: 16'h5E16, cyc: 16'd480};
    vt[1] = '{n: 8'd0, s: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, c: 8'h01,
              f: 16'h0000, l: 16'h0000, cs: 16'h55AB, cyc: 16'd400};
    vt[2] = '{n: 8'd2, s: {16'h0000, 16'h0000, 16'h2222, 16'h1111}, c: 8'h10,
              f: 16'h0100, l: 16'h0200, cs: 16'h6789, cyc: 16'd560};
    vt[3] = '{n: 8'd3, s: {16'h0000, 16'h8001, 16'h00FF, 16'hFFFF}, c: 8'hFF,
              f: 16'hFFFF, l: 16'h0000, cs: 16'hD6AB, cyc: 16'd640};

    reset = 1'b0; samp_valid = 1'b0; samp_data = 16'h0000; start = 1'b0;
    ct = 8'h00; fsa = 16'h0000; lsa = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_line", transmitData, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", samp_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", samp_ready, 1'b1);

    for (int v = 0; v < 4; v++) begin
      pushed_q.delete();
      for (int k = 0; k < int'(vt[v].n); k++) begin
        push(vt[v].s[k], acc);
        check("push_accept", acc, 1'b1);
        pushed_q.push_back(vt[v].s[k]);
      end
      run_frame(vt[v].c, vt[v].f, vt[v].l, 1'b0, 1'b0, bc);
      check("busy_cycles", bc, vt[v].cyc);
      compare_frame(vt[v].c, vt[v].f, vt[v].l, vt[v].cs);
    end

    // Full buffer: 41 offered, only 40 accepted.
    pushed_q.delete();
    cs_m = 16'h55AA ^ {8'd40, 8'h22} ^ 16'hA5A5 ^ 16'h5A5A;
    for (int k = 1; k <= 41; k++) begin
      push(16'(k * 16'h0101), acc);
      check($sformatf("full_push%0d", k), acc, (k <= 40) ? 1'b1 : 1'b0);
      if (k <= 40) begin
        pushed_q.push_back(16'(k * 16'h0101));
        cs_m = cs_m ^ 16'(k * 16'h0101);
      end
    end
    run_frame(8'h22, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0, bc);
    check("full_busy_cycles", bc, 32'd3600);
    check("full_len", rx_q.size(), 32'd90);
    if (rx_q.size() > 3) check("full_lsn", rx_q[3], 8'h28);
    compare_frame(8'h22, 16'hA5A5, 16'h5A5A, cs_m);

    // start and push during SEND are ignored.
    pushed_q.delete();
    push(16'h0ABC, acc);
    pushed_q.push_back(16'h0ABC);
    run_frame(8'h00, 16'h1234, 16'h1234, 1'b1, 1'b0, bc);
    check("disturb_cycles", bc, 32'd480);
    compare_frame(8'h00, 16'h1234, 16'h1234, 16'h5E16);
    pushed_q.delete();
    run_frame(8'h01, 16'h0000, 16'h0000, 1'b0, 1'b0, bc);
    compare_frame(8'h01, 16'h0000, 16'h0000, 16'h55AB);

    // Reset in the middle of byte 5 of a two-sample frame.
    push(16'h1111, acc);
    push(16'h2222, acc);
    @(negedge clk);
    start = 1'b1; ct = 8'h00; fsa = 16'h0000; lsa = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5 * 10 * CPB + 2 * CPB) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_line", transmitData, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", samp_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", samp_ready, 1'b1);
    pushed_q.delete();
    run_frame(8'h01, 16'h0000, 16'h0000, 1'b0, 1'b0, bc);
    check("post_rst_cycles", bc, 32'd400);
    compare_frame(8'h01, 16'h0000, 16'h0000, 16'h55AB);

    // Push offered in the start cycle is refused.
    pushed_q.delete();
    push(16'h0ABC, acc);
    pushed_q.push_back(16'h0ABC);
    run_frame(8'h00, 16'h1234, 16'h1234, 1'b0, 1'b1, bc);
    check("pas_cycles", bc, 32'd480);
    compare_frame(8'h00, 16'h1234, 16'h1234, 16'h5E16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
